// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit for MULT/MULTU/DIV/DIVU. Owns HI/LO, serves MFHI/MFLO/MTHI/MTLO,
// and requests a pipeline stall while an operation is in flight.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_EX,
  input  logic [1:0]       op_EX,
  input  logic [WIDTH-1:0] dataA_EX,
  input  logic [WIDTH-1:0] dataB_EX,
  input  logic             hilo_rd_EX,
  input  logic             hilo_sel_EX,
  input  logic             wr_hi_EX,
  input  logic             wr_lo_EX,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH-1:0]   b_q;
  logic               is_div_q, div0_q, a_neg_q, b_neg_q;

  // Operand decode: magnitudes of the forwarded operands, sign only for MULT/DIV.
  logic             a_neg_d, b_neg_d, div0_d;
  logic [WIDTH-1:0] a_mag_d, b_mag_d;

  always_comb begin
    a_neg_d = ~op_EX[0] & dataA_EX[WIDTH-1];
    b_neg_d = ~op_EX[0] & dataB_EX[WIDTH-1];
    a_mag_d = a_neg_d ? -dataA_EX : dataA_EX;
    b_mag_d = b_neg_d ? -dataB_EX : dataB_EX;
    div0_d  = op_EX[1] & (dataB_EX == '0);
  end

  // Iteration step. Multiply: {acc, multiplier} shifts right, adding the multiplicand
  // when the low bit is set. Divide: {remainder, quotient} shifts left with a trial subtract.
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH:0]   div_sh;
  logic [2*WIDTH-1:0] p_d;

  always_comb begin
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? b_q : '0)};
    div_sh   = {p_q, 1'b0};
    div_diff = div_sh[2*WIDTH:WIDTH] - {1'b0, b_q};
    if (is_div_q) begin
      p_d = div_diff[WIDTH] ? div_sh[2*WIDTH-1:0]
                            : {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
    end else begin
      p_d = {mul_sum, p_q[WIDTH-1:1]};
    end
  end

  // Sign correction: remainder follows the dividend, quotient/product follow the sign XOR.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, hi_d, lo_d;

  always_comb begin
    prod_fix = (a_neg_q ^ b_neg_q) ? -p_q : p_q;
    quo_fix  = (a_neg_q ^ b_neg_q) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    rem_fix  = a_neg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    if (div0_q) begin
      hi_d = p_q[WIDTH-1:0];
      lo_d = '1;
    end else if (is_div_q) begin
      hi_d = rem_fix;
      lo_d = quo_fix;
    end else begin
      hi_d = prod_fix[2*WIDTH-1:WIDTH];
      lo_d = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      p_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_EX) begin
            is_div_q <= op_EX[1];
            div0_q   <= div0_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            b_q      <= b_mag_d;
            // Divide-by-zero keeps the raw dividend so it can be returned in HI.
            p_q      <= {{WIDTH{1'b0}}, (div0_d ? dataA_EX : a_mag_d)};
            cnt_q    <= '0;
            state_q  <= div0_d ? S_FIX : S_CALC;
          end else begin
            if (wr_hi_EX) hi_q <= dataA_EX;
            if (wr_lo_EX) lo_q <= dataA_EX;
          end
        end
        S_CALC: begin
          p_q <= p_d;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stall handshake: while busy, any mul/div, HI/LO read or HI/LO write in EX raises
  // stall_req; upstream holds and re-presents that instruction until stall_req drops.
  // A start seen while busy is never accepted.
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIX);
  assign stall_req  = busy & (start_EX | hilo_rd_EX | wr_hi_EX | wr_lo_EX);
  assign hilo_rdata = hilo_sel_EX ? hi_q : lo_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: arithmetic results, latency, stalls, MTHI/MTLO and async reset.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_EX = 1'b0;
  logic [1:0]  op_EX = 2'd0;
  logic [31:0] dataA_EX = '0;
  logic [31:0] dataB_EX = '0;
  logic        hilo_rd_EX = 1'b0;
  logic        hilo_sel_EX = 1'b0;
  logic        wr_hi_EX = 1'b0;
  logic        wr_lo_EX = 1'b0;
  logic        busy, stall_req, done;
  logic [31:0] hilo_rdata;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  localparam logic [1:0] OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3;

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start_EX(start_EX), .op_EX(op_EX),
    .dataA_EX(dataA_EX), .dataB_EX(dataB_EX), .hilo_rd_EX(hilo_rd_EX),
    .hilo_sel_EX(hilo_sel_EX), .wr_hi_EX(wr_hi_EX), .wr_lo_EX(wr_lo_EX),
    .busy(busy), .stall_req(stall_req), .done(done), .hilo_rdata(hilo_rdata),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done with a cycle budget; returns the number of edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    hilo_sel_EX = 1'b0;
    #1;
    check({tag, "_lo"}, hilo_rdata, exp_lo);
    hilo_sel_EX = 1'b1;
    #1;
    check({tag, "_hi"}, hilo_rdata, exp_hi);
  endtask

  // Total cycles = start cycle + edges waited for done + the FIX cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_cyc);
    int n;
    op_EX = op; dataA_EX = a; dataB_EX = b; start_EX = 1'b1;
    tick();
    start_EX = 1'b0;
    wait_done(n);
    check({tag, "_latency"}, 32'(n + 2), 32'(exp_cyc));
    check({tag, "_busy_in_fix"}, {31'b0, busy}, 32'd1);
    tick();
    check({tag, "_done_clear"}, {31'b0, done}, 32'd0);
    check_hilo(tag, exp_hi, exp_lo);
  endtask

  // Decode must never present a mul/div start together with MTHI/MTLO while idle.
  always @(negedge clk) begin
    if (reset && !busy) begin
      assert (!(start_EX && (wr_hi_EX || wr_lo_EX))) else begin
        failures++;
        $error("FAIL decode_conflict observed start=%0b wr_hi=%0b wr_lo=%0b expected no overlap",
               start_EX, wr_hi_EX, wr_lo_EX);
      end
    end
  end

  initial begin
    int n;
    #2;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_state", {30'b0, state_dbg}, 32'd0);
    check_hilo("reset", 32'h0, 32'h0);
    tick();
    reset = 1'b1;
    tick();

    run_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd5,       32'hFFFFFFFF, 32'hFFFFFFF1, 34);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34);
    run_op("mult_nn",   OP_MULT,  32'hFFFFFFFC, 32'hFFFFFFFA, 32'h00000000, 32'h00000018, 34);
    run_op("divu",      OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       34);
    run_op("div_negA",  OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    run_op("div_negB",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34);
    run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34);
    run_op("div_zero",  OP_DIV,   32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 2);

    // Read of LO held from the third cycle of a MULT stalls through FIX.
    op_EX = OP_MULT; dataA_EX = 32'd3; dataB_EX = 32'd4; start_EX = 1'b1;
    tick();
    start_EX = 1'b0;
    tick();
    hilo_rd_EX = 1'b1; hilo_sel_EX = 1'b0;
    #1;
    check("stall_read_calc", {31'b0, stall_req}, 32'd1);
    wait_done(n);
    check("stall_read_fix", {31'b0, stall_req}, 32'd1);
    tick();
    check("stall_read_release", {31'b0, stall_req}, 32'd0);
    check("first_read_lo", hilo_rdata, 32'd12);
    hilo_rd_EX = 1'b0;

    // MTHI and a second start while busy both stall and change nothing.
    op_EX = OP_MULTU; dataA_EX = 32'd2; dataB_EX = 32'd3; start_EX = 1'b1;
    tick();
    start_EX = 1'b0;
    wr_hi_EX = 1'b1; dataA_EX = 32'hDEADBEEF;
    #1;
    check("stall_mthi_busy", {31'b0, stall_req}, 32'd1);
    wr_hi_EX = 1'b0;
    op_EX = OP_DIVU; dataA_EX = 32'd100; dataB_EX = 32'd7; start_EX = 1'b1;
    #1;
    check("stall_start_busy", {31'b0, stall_req}, 32'd1);
    tick();
    start_EX = 1'b0;
    wait_done(n);
    tick();
    check_hilo("busy_ignored", 32'h0, 32'd6);

    wr_hi_EX = 1'b1; dataA_EX = 32'hCAFEF00D;
    #1;
    check("mthi_idle_nostall", {31'b0, stall_req}, 32'd0);
    tick();
    wr_hi_EX = 1'b0;
    check_hilo("mthi", 32'hCAFEF00D, 32'd6);
    wr_hi_EX = 1'b1; wr_lo_EX = 1'b1; dataA_EX = 32'h13579BDF;
    tick();
    wr_hi_EX = 1'b0; wr_lo_EX = 1'b0;
    check_hilo("mthi_mtlo", 32'h13579BDF, 32'h13579BDF);

    // Asynchronous reset in the middle of a DIVU.
    op_EX = OP_DIVU; dataA_EX = 32'd100; dataB_EX = 32'd7; start_EX = 1'b1;
    tick();
    start_EX = 1'b0;
    repeat (9) tick();
    check("busy_before_reset", {31'b0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_busy", {31'b0, busy}, 32'd0);
    check("async_reset_state", {30'b0, state_dbg}, 32'd0);
    check_hilo("async_reset", 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("after_reset_done", {31'b0, done}, 32'd0);
    run_op("mult_6x7", OP_MULT, 32'd6, 32'd7, 32'h0, 32'd42, 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- EX-stage consumer of the ID/EX pipeline register outputs.
- Runs the multi-cycle MIPS MULT/MULTU/DIV/DIVU operations and owns the HI/LO registers.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- While an operation is in flight, it drives a stall request back toward the front of the pipeline; the hazard logic turns this into IF/ID hold and flush_IDEX.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-low; 0 = reset.
- start_EX  input  1  valid mul/div instruction present in EX this cycle.
- op_EX  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- dataA_EX  input  WIDTH  rs operand, forwarded.
- dataB_EX  input  WIDTH  rt operand, forwarded.
- hilo_rd_EX  input  1  MFHI/MFLO in EX this cycle.
- hilo_sel_EX  input  1  0=LO, 1=HI.
- wr_hi_EX  input  1  MTHI in EX.
- wr_lo_EX  input  1  MTLO in EX.
- busy  output  1  operation in flight (state is not IDLE).
- stall_req  output  1  hold upstream and flush ID/EX this cycle.
- done  output  1  one-cycle pulse when HI/LO are updated.
- hilo_rdata  output  WIDTH  combinational HI or LO selected by hilo_sel_EX.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; HI=LO=0; counter=0; busy=0; done=0.
  - All internal datapath registers cleared.
  - A reset mid-operation abandons the operation; HI/LO are not updated.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start_EX=1 latches operands into internal registers and goes to CALC with counter=0.
  - Exception: DIV/DIVU with dataB_EX=0 goes straight to FIX.
- CALC:
  - One iteration per clock; goes to FIX after WIDTH iterations, i.e. counter reaches WIDTH-1.
- FIX:
  - Applies sign correction and writes HI/LO at the clock edge.
  - done=1 during this cycle; returns to IDLE next cycle.
- Latency: start accepted at edge N; HI/LO valid after edge N+WIDTH+1 (34 cycles at default); div-by-zero takes 2 cycles.
- Multiply:
  - Radix-2 shift-add over the unsigned magnitudes; 2*WIDTH-bit product.
  - Signed (MULT): magnitudes of both operands; product negated in FIX if the signs differ.
  - HI = product[2W-1:W], LO = product[W-1:0].
- Divide:
  - Restoring division on the magnitudes.
  - LO = quotient, HI = remainder.
  - DIV: quotient negative if the operand signs differ; remainder takes the dividend's sign.
  - Most-negative / -1 yields LO=0x80000000, HI=0. No trap.
- Divide by zero: LO=all ones, HI=dividend unchanged (raw dataA).
- hilo_rdata is combinational from the HI/LO registers.
  - No bypass of an in-flight result; a read while busy stalls instead.
- stall_req = busy & (start_EX | hilo_rd_EX | wr_hi_EX | wr_lo_EX).
  - Combinational.
  - Upstream keeps the instruction and re-presents it until stall_req=0.
  - Any start_EX seen while busy is ignored.
- MTHI/MTLO:
  - Take effect at the clock edge when state=IDLE and start_EX=0.
  - wr_hi and wr_lo together write both registers with their respective data: HI from dataA_EX, LO from dataA_EX.
- Simultaneous start_EX and wr_* in IDLE: start wins and the write is dropped. Decode must never produce this combination; the bench flags it as an assertion.
- Request in the FIX cycle: busy is still 1, so any request stalls one more cycle. A read in the following IDLE cycle sees the new HI/LO.
- Counter never wraps: it is cleared on entry to CALC and saturates on exit.

Test Plan:
- MULT, A=0xFFFFFFFD (-3), B=5 -> done after 34 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU, A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIVU, A=100, B=7 -> LO=14, HI=2. DIV, A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV, A=0x12345678, B=0 -> done 2 cycles after start; LO=0xFFFFFFFF, HI=0x12345678.
- Start MULT, then hold hilo_rd_EX=1 with sel=LO from cycle 3 -> stall_req=1 through the FIX cycle; first unstalled read returns the new LO. MTHI while busy stalls; in IDLE, MTHI with A=0xCAFEF00D -> HI=0xCAFEF00D after one edge.
- Pull reset low at cycle 10 of a DIVU -> busy=0, HI=LO=0 immediately (async). After release, a new MULT 6*7 -> LO=42, HI=0.
